// File: rtl/icache_sa_pkg.sv
// Shared types and address-field helpers for the set-associative instruction cache.
package icache_sa_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int off_bits(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int line_words, input int sets);
    return 32 - off_bits(line_words) - idx_bits(sets);
  endfunction

  // Width of a selector over n items; never zero so single-item cases still have a port.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] word_field(input logic [31:0] addr, input int line_words);
    return (addr >> 2) & 32'(line_words - 1);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag and data arrays, hit compare and a single word-write port.
module icache_way
  import icache_sa_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 22,
  parameter int WW         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  input  logic [WW-1:0]    rd_word_i,
  output logic             hit_o,
  output logic             valid_o,
  output logic [31:0]      rdata_o,
  input  logic             tag_we_i,
  input  logic [IDX_W-1:0] tag_idx_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             data_we_i,
  input  logic [IDX_W-1:0] data_idx_i,
  input  logic [WW-1:0]    word_i,
  input  logic [31:0]      data_i,
  input  logic             set_valid_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  // A tag write always invalidates the line until its last word lands.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= '0;
    end else begin
      if (tag_we_i)    valid_q[tag_idx_i]  <= 1'b0;
      if (set_valid_i) valid_q[data_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we_i)  tag_q[tag_idx_i]           <= tag_i;
    if (data_we_i) data_q[data_idx_i][word_i] <= data_i;
  end

  assign valid_o = valid_q[rd_idx_i];
  assign hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rdata_o = data_q[rd_idx_i][rd_word_i];

endmodule

// File: rtl/icache_sa.sv
// Set-associative icache top: lookup/hit mux, victim choice, refill FSM and memory handshake.
// Handshake: o_mreq/o_maddr stay stable until a cycle with i_mvalid=1, which consumes that word.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        o_hit,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_mreq,
  output logic [31:0] o_maddr,
  input  logic        i_mvalid,
  input  logic [31:0] i_mdata,
  output state_t      o_state
);

  localparam int OFF_W = off_bits(LINE_WORDS);
  localparam int IDX_W = idx_bits(SETS);
  localparam int TAG_W = tag_bits(LINE_WORDS, SETS);
  localparam int VW    = sel_bits(WAYS);
  localparam int WW    = sel_bits(LINE_WORDS);

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] victim_q, victim_d, victim_sel;
  logic [VW-1:0] rr_q [SETS];

  logic [IDX_W-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [WW-1:0]    lk_word;
  logic [WAYS-1:0]  hit_w, valid_w, tag_we_w, data_we_w;
  logic [31:0]      rdata_w [WAYS];
  logic [31:0]      rdata_or;
  logic             any_hit, start, last, fill_we, fill_done;

  assign lk_idx   = i_addr[OFF_W +: IDX_W];
  assign lk_tag   = i_addr[31 -: TAG_W];
  assign lk_word  = WW'(word_field(i_addr, LINE_WORDS));
  assign fill_idx = base_q[OFF_W +: IDX_W];

  assign start     = (state_q == IDLE) && i_req && !o_hit && !i_flush;
  assign last      = (cnt_q == WW'(LINE_WORDS - 1));
  assign fill_we   = (state_q == REFILL) && i_mvalid && !i_flush;
  assign fill_done = fill_we && last;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign tag_we_w[w]  = start && (victim_sel == VW'(w));
    assign data_we_w[w] = fill_we && (victim_q == VW'(w));

    icache_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W), .WW(WW)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (i_flush),
      .rd_idx_i   (lk_idx),
      .rd_tag_i   (lk_tag),
      .rd_word_i  (lk_word),
      .hit_o      (hit_w[w]),
      .valid_o    (valid_w[w]),
      .rdata_o    (rdata_w[w]),
      .tag_we_i   (tag_we_w[w]),
      .tag_idx_i  (lk_idx),
      .tag_i      (lk_tag),
      .data_we_i  (data_we_w[w]),
      .data_idx_i (fill_idx),
      .word_i     (cnt_q),
      .data_i     (i_mdata),
      .set_valid_i(data_we_w[w] && last)
    );
  end

  always_comb begin
    any_hit  = 1'b0;
    rdata_or = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_w[w]) begin
        any_hit  = 1'b1;
        rdata_or = rdata_or | rdata_w[w];
      end
    end
  end

  assign o_hit   = (state_q == IDLE) && any_hit;
  assign o_rdata = o_hit ? rdata_or : '0;

  // Lowest-index invalid way wins; the descending scan lets the lowest one overwrite last.
  always_comb begin
    victim_sel = rr_q[lk_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_w[w]) victim_sel = VW'(w);
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    victim_d = victim_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = REFILL;
          base_d   = {i_addr[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d    = '0;
          victim_d = victim_sel;
        end
      end
      REFILL: begin
        if (i_flush) begin
          state_d = IDLE;
        end else if (i_mvalid) begin
          if (last) state_d = IDLE;
          else      cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fill_done) begin
      rr_q[fill_idx] <= (WAYS == 1) ? '0 : VW'(rr_q[fill_idx] + 1'b1);
    end
  end

  assign o_busy  = (state_q == REFILL);
  assign o_mreq  = (state_q == REFILL);
  assign o_maddr = o_mreq ? (base_q + (32'(cnt_q) << 2)) : '0;
  assign o_state = state_q;

endmodule
